crono_multicanal: RTL and testbench

//  N-channel BCD countdown timer (hh:mm:ss), parametrised successor of the single-channel crono.

---
 rtl/crono_multicanal_pkg.sv | 48 ++++
 rtl/crono_multicanal_canal.sv | 90 +++++++++
 rtl/crono_multicanal.sv | 124 ++++++++++++
 tb/tb_crono_multicanal.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/crono_multicanal_pkg.sv
// Shared definitions for the multi-channel BCD countdown timer: FSM states,
// cursor and button codes, and BCD field arithmetic.
package crono_multicanal_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_ALARMA = 2'd2
    } canal_st_e;

    localparam logic [1:0] CUR_SEG  = 2'd0;
    localparam logic [1:0] CUR_MIN  = 2'd1;
    localparam logic [1:0] CUR_HORA = 2'd2;

    localparam int BOT_UP   = 3;
    localparam int BOT_DOWN = 2;
    localparam int BOT_PREV = 1;
    localparam int BOT_NEXT = 0;

    localparam int SEL_EDIT_DEF = 2;
    localparam int SEL_RUN_DEF  = 8;

    localparam logic [7:0] MAX_MIN_SEG = 8'd59;

    function automatic logic [7:0] bcd_a_bin(input logic [7:0] f);
        return ({4'd0, f[7:4]} * 8'd10) + {4'd0, f[3:0]};
    endfunction

    function automatic logic [7:0] bin_a_bcd(input logic [7:0] b);
        logic [7:0] t;
        logic [7:0] u;
        t = b / 8'd10;
        u = b - (t * 8'd10);
        return (t << 4) | u;
    endfunction

    // One step up or down on a two-digit BCD field, wrapping between 0 and maxv.
    function automatic logic [7:0] campo_paso(input logic [7:0] f, input logic [7:0] maxv,
                                              input logic subir);
        logic [7:0] b;
        logic [7:0] nb;
        b = bcd_a_bin(f);
        if (subir) nb = (b >= maxv) ? 8'd0 : b + 8'd1;
        else       nb = (b == 8'd0) ? maxv : b - 8'd1;
        return bin_a_bcd(nb);
    endfunction

endpackage

// File: rtl/crono_multicanal_canal.sv
// One timer channel: preset register, live count, IDLE/RUN/ALARMA FSM and
// BCD countdown with borrow ss -> mm -> hh.
module crono_multicanal_canal
    import crono_multicanal_pkg::*;
#(
    parameter int HORA_MAX     = 23,
    parameter int MODO_REPETIR = 0
) (
    input  logic        reloj,
    input  logic        resetM,
    input  logic        tick_i,
    input  logic        run_i,
    input  logic        ack_i,
    input  logic        wr_i,
    input  logic [23:0] wr_dato_i,
    output logic [23:0] preset_o,
    output logic [23:0] cuenta_o,
    output logic        flag_o
);

    canal_st_e   estado_q, estado_d;
    logic [23:0] preset_q, preset_d;
    logic [23:0] cuenta_q, cuenta_d;
    logic [23:0] cuenta_dec;
    logic        flag_q, flag_d;

    assign cuenta_dec = {
        (cuenta_q[15:0] == 16'h0000) ? campo_paso(cuenta_q[23:16], 8'(HORA_MAX), 1'b0)
                                     : cuenta_q[23:16],
        (cuenta_q[7:0] == 8'h00) ? campo_paso(cuenta_q[15:8], MAX_MIN_SEG, 1'b0)
                                 : cuenta_q[15:8],
        campo_paso(cuenta_q[7:0], MAX_MIN_SEG, 1'b0)
    };

    always_comb begin
        estado_d = estado_q;
        preset_d = wr_i ? wr_dato_i : preset_q;
        cuenta_d = cuenta_q;
        flag_d   = flag_q & ~ack_i;
        case (estado_q)
            ST_IDLE: begin
                cuenta_d = preset_q;
                if (run_i && (preset_q != 24'h0)) estado_d = ST_RUN;
            end
            ST_RUN: begin
                // An acknowledge in the same cycle as a tick swallows that tick.
                if (!ack_i && tick_i && run_i) begin
                    if (cuenta_dec == 24'h0) begin
                        flag_d = 1'b1;
                        if ((MODO_REPETIR != 0) && (preset_q != 24'h0)) begin
                            cuenta_d = preset_q;
                        end else begin
                            cuenta_d = 24'h0;
                            estado_d = ST_ALARMA;
                        end
                    end else begin
                        cuenta_d = cuenta_dec;
                    end
                end
            end
            ST_ALARMA: begin
                cuenta_d = 24'h0;
                if (ack_i) begin
                    estado_d = ST_IDLE;
                    cuenta_d = preset_q;
                end
            end
            default: estado_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge reloj or negedge resetM) begin
        if (!resetM) begin
            estado_q <= ST_IDLE;
            preset_q <= 24'h0;
            cuenta_q <= 24'h0;
            flag_q   <= 1'b0;
        end else begin
            estado_q <= estado_d;
            preset_q <= preset_d;
            cuenta_q <= cuenta_d;
            flag_q   <= flag_d;
        end
    end

    assign preset_o = preset_q;
    assign cuenta_o = cuenta_q;
    assign flag_o   = flag_q;

endmodule

// File: rtl/crono_multicanal.sv
// N-channel BCD hh:mm:ss countdown timer: button edge detection, field cursor,
// preset editing of the selected channel and registered display mux.
module crono_multicanal
    import crono_multicanal_pkg::*;
#(
    parameter int N_CANALES    = 2,
    parameter int HORA_MAX     = 23,
    parameter int MODO_REPETIR = 0,
    parameter int SEL_EDIT     = SEL_EDIT_DEF,
    parameter int SEL_RUN      = SEL_RUN_DEF,
    localparam int SEL_W       = (N_CANALES > 1) ? $clog2(N_CANALES) : 1
) (
    input  logic                 reloj,
    input  logic                 resetM,
    input  logic                 tick_1hz,
    input  logic [3:0]           Selec_Demux_DD,
    input  logic [3:0]           IN_bot_cr,
    input  logic [SEL_W-1:0]     canal_sel,
    input  logic                 A_A,
    input  logic                 READ,
    output logic [23:0]          alarma,
    output logic [23:0]          com_alarma,
    output logic [N_CANALES-1:0] bit_alarma,
    output logic [1:0]           Contador_pos_cr
);

    logic [3:0]  bot_prev_q;
    logic        aa_prev_q;
    logic [1:0]  cursor_q, cursor_d;
    logic [23:0] alarma_q, com_q;
    logic [3:0]  bot_flanco;
    logic        aa_flanco, edit_en, run_en;
    logic        subir, bajar, sig, ant, campo_wr;
    logic [23:0] preset_arr [N_CANALES];
    logic [23:0] cuenta_arr [N_CANALES];
    logic [23:0] preset_sel, cuenta_sel, wr_dato;
    logic [7:0]  campo, campo_max, campo_nuevo;

    assign bot_flanco = IN_bot_cr & ~bot_prev_q;
    assign aa_flanco  = A_A & ~aa_prev_q;
    assign edit_en    = (Selec_Demux_DD == 4'(SEL_EDIT)) && READ;
    assign run_en     = (Selec_Demux_DD == 4'(SEL_RUN));

    // Only the highest-priority button edge acts: up > down > next > prev.
    assign subir = edit_en & bot_flanco[BOT_UP];
    assign bajar = edit_en & ~bot_flanco[BOT_UP] & bot_flanco[BOT_DOWN];
    assign sig   = edit_en & ~bot_flanco[BOT_UP] & ~bot_flanco[BOT_DOWN] & bot_flanco[BOT_NEXT];
    assign ant   = edit_en & ~bot_flanco[BOT_UP] & ~bot_flanco[BOT_DOWN] & ~bot_flanco[BOT_NEXT]
                 & bot_flanco[BOT_PREV];
    assign campo_wr = subir | bajar;

    // An out-of-range canal_sel matches no channel, so it reads as zero.
    always_comb begin
        preset_sel = 24'h0;
        cuenta_sel = 24'h0;
        for (int i = 0; i < N_CANALES; i++) begin
            if (int'(canal_sel) == i) begin
                preset_sel = preset_arr[i];
                cuenta_sel = cuenta_arr[i];
            end
        end
    end

    always_comb begin
        campo     = preset_sel[7:0];
        campo_max = MAX_MIN_SEG;
        if (cursor_q == CUR_MIN) begin
            campo = preset_sel[15:8];
        end else if (cursor_q == CUR_HORA) begin
            campo     = preset_sel[23:16];
            campo_max = 8'(HORA_MAX);
        end
        campo_nuevo = campo_paso(campo, campo_max, subir);
        wr_dato = preset_sel;
        if (cursor_q == CUR_MIN)       wr_dato[15:8]  = campo_nuevo;
        else if (cursor_q == CUR_HORA) wr_dato[23:16] = campo_nuevo;
        else                           wr_dato[7:0]   = campo_nuevo;
    end

    always_comb begin
        cursor_d = cursor_q;
        if (sig)      cursor_d = (cursor_q == CUR_HORA) ? CUR_SEG : cursor_q + 2'd1;
        else if (ant) cursor_d = (cursor_q == CUR_SEG) ? CUR_HORA : cursor_q - 2'd1;
    end

    always_ff @(posedge reloj or negedge resetM) begin
        if (!resetM) begin
            bot_prev_q <= 4'h0;
            aa_prev_q  <= 1'b0;
            cursor_q   <= CUR_SEG;
            alarma_q   <= 24'h0;
            com_q      <= 24'h0;
        end else begin
            bot_prev_q <= IN_bot_cr;
            aa_prev_q  <= A_A;
            cursor_q   <= cursor_d;
            alarma_q   <= cuenta_sel;
            com_q      <= preset_sel;
        end
    end

    for (genvar gi = 0; gi < N_CANALES; gi++) begin : g_canal
        crono_multicanal_canal #(
            .HORA_MAX     (HORA_MAX),
            .MODO_REPETIR (MODO_REPETIR)
        ) u_canal (
            .reloj     (reloj),
            .resetM    (resetM),
            .tick_i    (tick_1hz),
            .run_i     (run_en),
            .ack_i     (aa_flanco),
            .wr_i      (campo_wr && (int'(canal_sel) == gi)),
            .wr_dato_i (wr_dato),
            .preset_o  (preset_arr[gi]),
            .cuenta_o  (cuenta_arr[gi]),
            .flag_o    (bit_alarma[gi])
        );
    end

    assign alarma          = alarma_q;
    assign com_alarma      = com_q;
    assign Contador_pos_cr = cursor_q;

endmodule

// File: tb/tb_crono_multicanal.sv
// Scoreboard bench for crono_multicanal: a one-shot instance and an
// auto-repeat instance share stimulus; expectations queued, then drained.
module tb_crono_multicanal;

    logic        reloj = 1'b0;
    logic        resetM = 1'b0;
    logic        tick_1hz = 1'b0;
    logic        A_A = 1'b0;
    logic        READ = 1'b0;
    logic [3:0]  Selec_Demux_DD = 4'd0;
    logic [3:0]  IN_bot_cr = 4'd0;
    logic [0:0]  canal_sel = 1'b0;
    logic [23:0] alarma, com_alarma, alarma_r, com_alarma_r;
    logic [1:0]  bit_alarma, bit_alarma_r, pos, pos_r;

    int vectores = 0;
    int fallos   = 0;

    localparam logic [3:0] B_UP = 4'b1000, B_DOWN = 4'b0100, B_PREV = 4'b0010, B_NEXT = 4'b0001;
    localparam int O_AL = 0, O_COM = 1, O_BIT = 2, O_POS = 3, O_AL_R = 4, O_BIT_R = 5;

    typedef struct {
        string       tag;
        int          campo;
        logic [31:0] esp;
    } esp_t;
    esp_t cola[$];

    always #5 reloj = ~reloj;

    crono_multicanal dut (
        .reloj(reloj), .resetM(resetM), .tick_1hz(tick_1hz), .Selec_Demux_DD(Selec_Demux_DD),
        .IN_bot_cr(IN_bot_cr), .canal_sel(canal_sel), .A_A(A_A), .READ(READ),
        .alarma(alarma), .com_alarma(com_alarma), .bit_alarma(bit_alarma), .Contador_pos_cr(pos)
    );

    crono_multicanal #(.MODO_REPETIR(1)) dut_r (
        .reloj(reloj), .resetM(resetM), .tick_1hz(tick_1hz), .Selec_Demux_DD(Selec_Demux_DD),
        .IN_bot_cr(IN_bot_cr), .canal_sel(canal_sel), .A_A(A_A), .READ(READ),
        .alarma(alarma_r), .com_alarma(com_alarma_r), .bit_alarma(bit_alarma_r),
        .Contador_pos_cr(pos_r)
    );

    task automatic comprobar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        vectores++;
        if (obs !== esp) begin
            fallos++;
            $display("FAIL %s: got %h, expected %h", tag, obs, esp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    function automatic logic [31:0] observado(input int campo);
        case (campo)
            O_AL:    return {8'h0, alarma};
            O_COM:   return {8'h0, com_alarma};
            O_BIT:   return {30'h0, bit_alarma};
            O_POS:   return {30'h0, pos};
            O_AL_R:  return {8'h0, alarma_r};
            O_BIT_R: return {30'h0, bit_alarma_r};
            default: return 32'hffff_ffff;
        endcase
    endfunction

    task automatic esperar(input string tag, input int campo, input logic [31:0] esp);
        esp_t e;
        e.tag = tag; e.campo = campo; e.esp = esp;
        cola.push_back(e);
    endtask

    task automatic verificar(input int ciclos);
        esp_t e;
        repeat (ciclos) @(negedge reloj);
        while (cola.size() > 0) begin
            e = cola.pop_front();
            comprobar(e.tag, observado(e.campo), e.esp);
        end
    endtask

    task automatic pulsar(input logic [3:0] b, input int n);
        for (int k = 0; k < n; k++) begin
            IN_bot_cr = b;
            @(negedge reloj);
            IN_bot_cr = 4'd0;
            @(negedge reloj);
        end
    endtask

    task automatic pulso(input logic t, input logic a);
        tick_1hz = t;
        A_A = a;
        @(negedge reloj);
        tick_1hz = 1'b0;
        A_A = 1'b0;
        @(negedge reloj);
    endtask

    task automatic reiniciar();
        resetM = 1'b0;
        repeat (2) @(negedge reloj);
        resetM = 1'b1;
        @(negedge reloj);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge reloj);
        esperar("rst_alarma", O_AL, 0);
        esperar("rst_com", O_COM, 0);
        esperar("rst_bit", O_BIT, 0);
        esperar("rst_pos", O_POS, 0);
        verificar(0);
        resetM = 1'b1;
        @(negedge reloj);

        // Field-by-field edit of ch0
        Selec_Demux_DD = 4'd2; READ = 1'b1; canal_sel = 1'b0;
        pulsar(B_UP, 3); pulsar(B_NEXT, 1); pulsar(B_UP, 4); pulsar(B_NEXT, 1); pulsar(B_UP, 2);
        esperar("edit_com", O_COM, 24'h020403);
        esperar("edit_pos", O_POS, 2);
        esperar("edit_idle_count", O_AL, 24'h020403);
        verificar(2);

        // Wrap-around and priority
        pulsar(B_NEXT, 1);
        esperar("cursor_wrap_next", O_POS, 0); verificar(1);
        pulsar(B_DOWN, 3);
        esperar("sec_down_to_00", O_COM, 24'h020400); verificar(1);
        pulsar(B_DOWN, 1);
        esperar("sec_00_down", O_COM, 24'h020459); verificar(1);
        pulsar(B_PREV, 1);
        esperar("cursor_wrap_prev", O_POS, 2); verificar(1);
        pulsar(B_DOWN, 3);
        esperar("hr_00_down", O_COM, 24'h230459); verificar(1);
        pulsar(B_UP, 1);
        esperar("hr_max_up", O_COM, 24'h000459); verificar(1);
        pulsar(B_UP | B_NEXT, 1);
        esperar("up_next_com", O_COM, 24'h010459);
        esperar("up_next_pos", O_POS, 2); verificar(1);
        READ = 1'b0; pulsar(B_UP, 1); READ = 1'b1;
        esperar("read_low", O_COM, 24'h010459); verificar(1);
        Selec_Demux_DD = 4'd0; pulsar(B_NEXT, 1); Selec_Demux_DD = 4'd2;
        esperar("cursor_held", O_POS, 2); verificar(1);

        // Countdown, pause and acknowledge
        reiniciar();
        Selec_Demux_DD = 4'd2; READ = 1'b1; canal_sel = 1'b0;
        pulsar(B_UP, 2);
        Selec_Demux_DD = 4'd8;
        esperar("run_start", O_AL, 24'h000002); verificar(2);
        pulso(1'b1, 1'b0);
        esperar("tick1", O_AL, 24'h000001);
        esperar("tick1_bit", O_BIT, 0); verificar(2);
        Selec_Demux_DD = 4'd7;
        for (int k = 0; k < 5; k++) pulso(1'b1, 1'b0);
        esperar("pause", O_AL, 24'h000001); verificar(2);
        Selec_Demux_DD = 4'd8;
        pulso(1'b1, 1'b0);
        esperar("expire", O_AL, 24'h000000);
        esperar("expire_bit", O_BIT, 2'b01); verificar(2);
        pulso(1'b1, 1'b0);
        esperar("alarm_hold", O_AL, 24'h000000); verificar(2);
        Selec_Demux_DD = 4'd2;
        pulso(1'b0, 1'b1);
        esperar("ack_count", O_AL, 24'h000002);
        esperar("ack_bit", O_BIT, 0); verificar(2);

        // ch0 zero preset stays idle; ch1 borrow
        pulsar(B_DOWN, 2);
        esperar("ch0_zero", O_COM, 24'h000000); verificar(1);
        canal_sel = 1'b1;
        pulsar(B_PREV, 1); pulsar(B_UP, 1);
        esperar("ch1_preset", O_COM, 24'h010000); verificar(2);
        Selec_Demux_DD = 4'd8;
        esperar("ch1_run", O_AL, 24'h010000); verificar(2);
        pulso(1'b1, 1'b0);
        esperar("borrow", O_AL, 24'h005959);
        esperar("borrow_bit", O_BIT, 0); verificar(2);
        canal_sel = 1'b0;
        esperar("ch0_idle", O_AL, 24'h000000);
        esperar("ch0_noalarm", O_BIT, 0); verificar(2);
        canal_sel = 1'b1;
        repeat (2) @(negedge reloj);

        // Asynchronous reset mid-run, off the clock edge
        @(posedge reloj);
        #1 resetM = 1'b0;
        #1;
        esperar("arst_alarma", O_AL, 0);
        esperar("arst_com", O_COM, 0);
        esperar("arst_bit", O_BIT, 0);
        esperar("arst_pos", O_POS, 0);
        verificar(0);
        @(negedge reloj);
        resetM = 1'b1;
        @(negedge reloj);

        // Auto-repeat instance
        Selec_Demux_DD = 4'd2; READ = 1'b1; canal_sel = 1'b0;
        pulsar(B_UP, 1);
        Selec_Demux_DD = 4'd8;
        esperar("rep_start", O_AL_R, 24'h000001); verificar(2);
        pulso(1'b1, 1'b0);
        esperar("rep_reload", O_AL_R, 24'h000001);
        esperar("rep_flag", O_BIT_R, 2'b01);
        esperar("oneshot_zero", O_AL, 24'h000000);
        esperar("oneshot_flag", O_BIT, 2'b01); verificar(2);
        pulso(1'b0, 1'b1);
        esperar("rep_ack_flag", O_BIT_R, 0);
        esperar("rep_ack_count", O_AL_R, 24'h000001); verificar(2);
        pulso(1'b1, 1'b0);
        esperar("rep_again_flag", O_BIT_R, 2'b01);
        esperar("rep_again_count", O_AL_R, 24'h000001); verificar(2);
        pulso(1'b1, 1'b1);
        esperar("ack_tick_flag", O_BIT_R, 0);
        esperar("ack_tick_count", O_AL_R, 24'h000001); verificar(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectores, fallos);
        $finish;
    end

endmodule
